quant_sched_4x4: RTL and testbench

Sequencing and arbitration controller for the shared 4x4 quantizer datapath. Two requesters present transformed 4x4 coefficient blocks with a QP: source 0 is the intra path, source 1 the inter path. The block grants them round-robin and derives QP/6 and QP%6 iteratively. It drives the quantizer's operand, mode and enable pins, captures the quantized block, and hands it downstream on a valid/ready interface. It sits between the forward transform stage and entropy coding.

---
 rtl/quant_pkg.sv | 23 ++
 rtl/quant_sched_4x4_if.sv | 42 ++++
 rtl/qp_divmod6.sv | 47 ++++
 rtl/quant_sched_4x4.sv | 160 ++++++++++++++++
 tb/tb_quant_sched_4x4.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/quant_pkg.sv
`default_nettype none
// ============================================================================
// quant_pkg : shared types and constants for the 4x4 quantizer scheduler
// Revision  : 1.0
// ============================================================================
package quant_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    QUANT = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int   QP_MAX    = 51;
  localparam logic SRC_INTRA = 1'b0;
  localparam logic SRC_INTER = 1'b1;

  localparam int COEF_MSB = 15;
  typedef logic [15:0][COEF_MSB:0] coef_block_t;

endpackage
`default_nettype wire

// File: rtl/quant_sched_4x4_if.sv
`default_nettype none
// ============================================================================
// quant_sched_4x4_if : request, quantizer and output bundle of the scheduler
// Revision           : 1.0
// ============================================================================
interface quant_sched_4x4_if #(
  parameter int BIT_LENGTH = 15
);

  logic [1:0]                  req_valid;
  logic [1:0]                  req_ready;
  logic [5:0]                  req_qp0;
  logic [5:0]                  req_qp1;
  logic [15:0][BIT_LENGTH:0]   req_block0;
  logic [15:0][BIT_LENGTH:0]   req_block1;
  logic                        q_enable;
  logic                        q_mode;
  logic [15:0][BIT_LENGTH:0]   q_transformed;
  logic [3:0]                  q_qp_by_6;
  logic [2:0]                  q_qp_mod_6;
  logic [15:0][BIT_LENGTH:0]   q_quantized;
  logic                        out_valid;
  logic                        out_ready;
  logic [15:0][BIT_LENGTH:0]   out_block;
  logic                        out_src;
  logic [5:0]                  out_qp;

  // The scheduler side.
  modport slave (
    input  req_valid, req_qp0, req_qp1, req_block0, req_block1, q_quantized, out_ready,
    output req_ready, q_enable, q_mode, q_transformed, q_qp_by_6, q_qp_mod_6,
           out_valid, out_block, out_src, out_qp
  );

  modport master (
    output req_valid, req_qp0, req_qp1, req_block0, req_block1, q_quantized, out_ready,
    input  req_ready, q_enable, q_mode, q_transformed, q_qp_by_6, q_qp_mod_6,
           out_valid, out_block, out_src, out_qp
  );

endinterface
`default_nettype wire

// File: rtl/qp_divmod6.sv
`default_nettype none
// ============================================================================
// qp_divmod6 : iterative QP/6 and QP%6, one subtraction per cycle after load
// Revision   : 1.0
// ============================================================================
module qp_divmod6 (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [5:0] qp,
  output logic       busy,
  output logic [3:0] quo,
  output logic [2:0] rem
);

  logic [5:0] rem_q, rem_d;
  logic [3:0] quo_q, quo_d;

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    if (load) begin
      rem_d = qp;
      quo_d = 4'd0;
    end else if (rem_q >= 6'd6) begin
      rem_d = rem_q - 6'd6;
      quo_d = quo_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q <= 6'd0;
      quo_q <= 4'd0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  // Once busy drops the remainder is below 6, so the low three bits hold it.
  assign busy = (rem_q >= 6'd6);
  assign quo  = quo_q;
  assign rem  = rem_q[2:0];

endmodule
`default_nettype wire

// File: rtl/quant_sched_4x4.sv
`default_nettype none
// ============================================================================
// quant_sched_4x4 : round-robin scheduler feeding the shared 4x4 quantizer
// Revision        : 1.0
// ============================================================================
module quant_sched_4x4
  import quant_pkg::*;
#(
  parameter int BIT_LENGTH    = 15,
  parameter int QUANT_LATENCY = 1,
  parameter int QP_MAX        = quant_pkg::QP_MAX
) (
  input  logic             clk,
  input  logic             reset,
  quant_sched_4x4_if.slave bus
);

  typedef logic [15:0][BIT_LENGTH:0] blk_t;

  localparam int               CNT_W    = $clog2(QUANT_LATENCY + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANT_LATENCY);
  localparam logic [5:0]       QP_CLAMP = 6'(QP_MAX);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             src_q, src_d;
  logic [5:0]       qp_q, qp_d;
  blk_t             blk_q, blk_d;
  blk_t             out_blk_q, out_blk_d;
  logic [3:0]       by6_q, by6_d;
  logic [2:0]       mod6_q, mod6_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       grant;
  logic [5:0] qp_req;
  logic [5:0] qp_sat;
  logic [1:0] req_ready;
  logic       load;
  logic       q_enable;
  logic       q_mode;
  logic       out_valid;
  logic       dm_busy;
  logic [3:0] dm_quo;
  logic [2:0] dm_rem;

  // On contention the source that did not win last time is served.
  always_comb begin
    grant = SRC_INTRA;
    case (bus.req_valid)
      2'b10:   grant = SRC_INTER;
      2'b11:   grant = ~last_grant_q;
      default: grant = SRC_INTRA;
    endcase
  end

  assign qp_req = grant ? bus.req_qp1 : bus.req_qp0;
  assign qp_sat = (qp_req > QP_CLAMP) ? QP_CLAMP : qp_req;

  qp_divmod6 u_divmod (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .qp    (qp_sat),
    .busy  (dm_busy),
    .quo   (dm_quo),
    .rem   (dm_rem)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    src_d        = src_q;
    qp_d         = qp_q;
    blk_d        = blk_q;
    out_blk_d    = out_blk_q;
    by6_d        = by6_q;
    mod6_d       = mod6_q;
    cnt_d        = cnt_q;
    req_ready    = 2'b00;
    load         = 1'b0;
    q_enable     = 1'b0;
    q_mode       = 1'b0;
    out_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid != 2'b00) begin
          req_ready[grant] = 1'b1;
          load             = 1'b1;
          last_grant_d     = grant;
          src_d            = grant;
          qp_d             = qp_sat;
          blk_d            = grant ? bus.req_block1 : bus.req_block0;
          state_d          = DIV;
        end
      end
      DIV: begin
        if (!dm_busy) begin
          by6_d   = dm_quo;
          mod6_d  = dm_rem;
          cnt_d   = '0;
          state_d = QUANT;
        end
      end
      QUANT: begin
        q_enable = 1'b1;
        q_mode   = (src_q == SRC_INTRA);
        if (cnt_q == CNT_LAST) begin
          out_blk_d = bus.q_quantized;
          state_d   = OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= SRC_INTER;
      src_q        <= 1'b0;
      qp_q         <= 6'd0;
      blk_q        <= '0;
      out_blk_q    <= '0;
      by6_q        <= 4'd0;
      mod6_q       <= 3'd0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      src_q        <= src_d;
      qp_q         <= qp_d;
      blk_q        <= blk_d;
      out_blk_q    <= out_blk_d;
      by6_q        <= by6_d;
      mod6_q       <= mod6_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.q_enable      = q_enable;
  assign bus.q_mode        = q_mode;
  assign bus.q_transformed = blk_q;
  assign bus.q_qp_by_6     = by6_q;
  assign bus.q_qp_mod_6    = mod6_q;
  assign bus.out_valid     = out_valid;
  assign bus.out_block     = out_blk_q;
  assign bus.out_src       = src_q;
  assign bus.out_qp        = qp_q;

endmodule
`default_nettype wire

// File: tb/tb_quant_sched_4x4.sv
`default_nettype none
// ============================================================================
// tb_quant_sched_4x4 : directed and random stimulus against a transaction model
// Revision           : 1.0
// ============================================================================
module tb_quant_sched_4x4;

  localparam int BL  = 15;
  localparam int QL  = 1;
  localparam int QPM = 51;

  typedef logic [15:0][BL:0] blk_t;
  typedef struct {
    logic src;
    int   qp;
    blk_t blk;
    int   hs;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc         = 0;
  int   n_checks    = 0;
  int   n_fail      = 0;
  int   hs_count    = 0;
  int   blocks_done = 0;
  int   en_cnt      = 0;
  logic m_last      = 1'b1;
  logic last_hs_src = 1'b0;
  bit   head_started = 1'b0;
  exp_t pend[$];

  quant_sched_4x4_if #(.BIT_LENGTH(BL)) bus ();

  quant_sched_4x4 #(
    .BIT_LENGTH    (BL),
    .QUANT_LATENCY (QL),
    .QP_MAX        (QPM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Stand-in quantizer: any function of block, QP/6 and QP%6 will do.
  function automatic blk_t qmodel(input blk_t b, input int by6, input int mod6);
    blk_t r;
    for (int i = 0; i < 16; i++) r[i] = b[i] ^ 16'((by6 << 8) | (mod6 << 4) | i);
    return r;
  endfunction

  function automatic blk_t rand_blk();
    blk_t r;
    for (int i = 0; i < 16; i++) r[i] = 16'($urandom);
    return r;
  endfunction

  initial bus.q_quantized = '0;
  always @(posedge clk)
    if (bus.q_enable)
      bus.q_quantized <= qmodel(bus.q_transformed, int'(bus.q_qp_by_6), int'(bus.q_qp_mod_6));

  // Transaction model: at most one block in flight; grants from req_valid history.
  always @(negedge clk) begin : monitor
    exp_t       h;
    exp_t       e;
    logic       g;
    logic [1:0] exp_ready;
    int         qraw;
    if (!reset) begin
      check_eq("rst_ctrl", 256'({bus.req_ready, bus.q_enable, bus.q_mode, bus.q_qp_by_6,
                                 bus.q_qp_mod_6, bus.out_valid, bus.out_src, bus.out_qp}), 256'(0));
      check_eq("rst_q_transformed", bus.q_transformed, 256'(0));
      check_eq("rst_out_block", bus.out_block, 256'(0));
      pend.delete();
      head_started = 1'b0;
      en_cnt       = 0;
      m_last       = 1'b1;
    end else begin
      g         = 1'b0;
      exp_ready = 2'b00;
      if (pend.size() == 0 && bus.req_valid != 2'b00) begin
        g         = (bus.req_valid == 2'b11) ? ~m_last : bus.req_valid[1];
        exp_ready = g ? 2'b10 : 2'b01;
      end
      check_eq("req_ready", 256'(bus.req_ready), 256'(exp_ready));
      if (pend.size() != 0) begin
        h = pend[0];
        if (bus.q_enable) begin
          en_cnt++;
          check_eq("q_mode", 256'(bus.q_mode), 256'(h.src == 1'b0));
          check_eq("q_qp_by_6", 256'(bus.q_qp_by_6), 256'(h.qp / 6));
          check_eq("q_qp_mod_6", 256'(bus.q_qp_mod_6), 256'(h.qp % 6));
          check_eq("q_transformed", bus.q_transformed, h.blk);
        end
        if (bus.out_valid) begin
          if (!head_started) begin
            check_eq("latency", 256'(cyc - h.hs), 256'(h.qp / 6 + QL + 3));
            check_eq("enable_cycles", 256'(en_cnt), 256'(QL + 1));
            head_started = 1'b1;
          end
          check_eq("out_src", 256'(bus.out_src), 256'(h.src));
          check_eq("out_qp", 256'(bus.out_qp), 256'(h.qp));
          check_eq("out_block", bus.out_block, qmodel(h.blk, h.qp / 6, h.qp % 6));
          check_eq("q_enable_in_out", 256'(bus.q_enable), 256'(0));
          if (bus.out_ready) begin
            void'(pend.pop_front());
            head_started = 1'b0;
            en_cnt       = 0;
            blocks_done++;
          end
        end
      end else begin
        check_eq("idle_out_valid", 256'(bus.out_valid), 256'(0));
        check_eq("idle_q_enable", 256'(bus.q_enable), 256'(0));
        if (exp_ready != 2'b00) begin
          qraw  = g ? int'(bus.req_qp1) : int'(bus.req_qp0);
          e.src = g;
          e.qp  = (qraw > QPM) ? QPM : qraw;
          e.blk = g ? bus.req_block1 : bus.req_block0;
          e.hs  = cyc;
          pend.push_back(e);
          m_last      = g;
          last_hs_src = g;
          hs_count++;
        end
      end
    end
  end

  task automatic wait_hs(input int target, input int budget);
    int n = 0;
    while (hs_count < target && n < budget) begin
      @(posedge clk); #1; n++;
    end
    if (hs_count < target) check_eq("handshake_timeout", 256'(hs_count), 256'(target));
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (blocks_done < target && n < budget) begin
      @(posedge clk); #1; n++;
    end
    if (blocks_done < target) check_eq("output_timeout", 256'(blocks_done), 256'(target));
  endtask

  task automatic single(input logic src, input logic [5:0] qp);
    int hs0 = hs_count;
    int d0  = blocks_done;
    if (src) begin bus.req_qp1 = qp; bus.req_block1 = rand_blk(); end
    else     begin bus.req_qp0 = qp; bus.req_block0 = rand_blk(); end
    bus.req_valid = src ? 2'b10 : 2'b01;
    wait_hs(hs0 + 1, 20);
    bus.req_valid = 2'b00;
    wait_done(d0 + 1, 40);
  endtask

  initial begin : driver
    int n;
    int hs0;
    int d0;
    int intra0;
    reset          = 1'b0;
    bus.req_valid  = 2'b00;
    bus.req_qp0    = 6'd0;
    bus.req_qp1    = 6'd0;
    bus.req_block0 = '0;
    bus.req_block1 = '0;
    bus.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    single(1'b0, 6'd28);
    single(1'b1, 6'd63);
    single(1'b0, 6'd0);
    single(1'b1, 6'd5);

    // Contention: eight blocks, both sources always requesting.
    hs0    = hs_count;
    d0     = blocks_done;
    intra0 = 0;
    bus.req_qp0 = 6'd7;  bus.req_block0 = rand_blk();
    bus.req_qp1 = 6'd13; bus.req_block1 = rand_blk();
    bus.req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      wait_hs(hs0 + k + 1, 30);
      if (last_hs_src == 1'b0) intra0++;
    end
    bus.req_valid = 2'b00;
    wait_done(d0 + 8, 40);
    check_eq("fair_intra_count", 256'(intra0), 256'(4));

    // Back-pressure with the other source waiting.
    hs0 = hs_count;
    d0  = blocks_done;
    bus.out_ready = 1'b0;
    bus.req_qp0 = 6'd12; bus.req_block0 = rand_blk();
    bus.req_qp1 = 6'd40; bus.req_block1 = rand_blk();
    bus.req_valid = 2'b11;
    n = 0;
    while (!bus.out_valid && n < 40) begin @(posedge clk); #1; n++; end
    if (!bus.out_valid) check_eq("out_valid_timeout", 256'(0), 256'(1));
    repeat (20) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_hs(hs0 + 2, 40);
    bus.req_valid = 2'b00;
    wait_done(d0 + 2, 40);

    // Reset while the quantizer is enabled for an intra block.
    hs0 = hs_count;
    bus.req_qp0 = 6'd20; bus.req_block0 = rand_blk();
    bus.req_valid = 2'b01;
    wait_hs(hs0 + 1, 20);
    bus.req_valid = 2'b00;
    n = 0;
    while (!bus.q_enable && n < 20) begin @(posedge clk); #1; n++; end
    check_eq("reached_quant", 256'(bus.q_enable), 256'(1));
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    hs0 = hs_count;
    d0  = blocks_done;
    bus.req_qp0 = 6'd9;  bus.req_block0 = rand_blk();
    bus.req_qp1 = 6'd33; bus.req_block1 = rand_blk();
    bus.req_valid = 2'b11;
    wait_hs(hs0 + 1, 20);
    bus.req_valid = 2'b00;
    check_eq("post_reset_grant", 256'(last_hs_src), 256'(0));
    wait_done(d0 + 1, 40);

    // Random traffic: requests come and go, downstream stalls at random.
    for (int k = 0; k < 600; k++) begin
      bus.req_valid  = 2'($urandom);
      bus.req_qp0    = 6'($urandom);
      bus.req_qp1    = 6'($urandom);
      bus.req_block0 = rand_blk();
      bus.req_block1 = rand_blk();
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    bus.req_valid = 2'b00;
    bus.out_ready = 1'b1;
    n = 0;
    while (pend.size() != 0 && n < 60) begin @(posedge clk); #1; n++; end
    check_eq("drain", 256'(pend.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
